fp_add_issuer: RTL and testbench

Issue/collect front end for the pipelined floating-point `adder_subtractor`. Accepts operand pairs through a valid/ready handshake, registers them onto the adder inputs, and tracks each operation through the adder's fixed-latency pipeline. Returns results in issue order through a credit-protected result FIFO, so no result is dropped under output back-pressure. Sits between the solver datapath (request side) and the adder (responder side).

---
 rtl/fp_add_issuer_if.sv | 29 ++
 rtl/fp_add_issuer.sv | 113 +++++++++++
 tb/tb_fp_add_issuer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_add_issuer_if.sv
// Bundle of the request, adder-facing and result signals of fp_add_issuer.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid may rise without waiting for ready.
interface fp_add_issuer_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_op;
   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic             add_op;
   logic [WIDTH-1:0] add_result;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             busy;

   modport master (
      output in_valid, in_a, in_b, in_op, add_result, out_ready,
      input  in_ready, add_a, add_b, add_op, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, add_result, out_ready,
      output in_ready, add_a, add_b, add_op, out_valid, out_data, busy
   );
endinterface

// File: rtl/fp_add_issuer.sv
// Issue/collect front end for a fixed-latency pipelined FP adder: registers operands,
// tracks ops with a valid shift register and returns results in order via a credit-protected FIFO.
module fp_add_issuer #(
   parameter int WIDTH      = 32,
   parameter int LATENCY    = 7,
   parameter int FIFO_DEPTH = 8
) (
   input logic            clk,
   input logic            rst_n,
   fp_add_issuer_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic             issue;
   logic             retire;
   logic             pop;
   logic [WIDTH-1:0] wr_data;
   logic [CW:0]      credit_used;

   logic [WIDTH-1:0]   add_a_q, add_a_d;
   logic [WIDTH-1:0]   add_b_q, add_b_d;
   logic               add_op_q, add_op_d;
   logic [LATENCY-1:0] vld_sr_q, vld_sr_d;
   logic [CW-1:0]      inflight_q, inflight_d;
   logic [CW-1:0]      count_q, count_d;
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0]   mem_q [FIFO_DEPTH];
   logic [WIDTH-1:0]   mem_d [FIFO_DEPTH];

   // Credit uses only registered state, so a pop frees space one cycle later.
   assign credit_used  = {1'b0, count_q} + {1'b0, inflight_q};
   assign bus.in_ready = rst_n && (credit_used < (CW+1)'(FIFO_DEPTH));

   assign issue   = bus.in_valid && bus.in_ready;
   assign retire  = vld_sr_q[LATENCY-1];
   assign pop     = bus.out_ready && (count_q != '0);
   // Collapse -0 (and +0) onto a single canonical zero.
   assign wr_data = (bus.add_result[WIDTH-2:0] == '0) ? '0 : bus.add_result;

   always_comb begin
      add_a_d    = add_a_q;
      add_b_d    = add_b_q;
      add_op_d   = add_op_q;
      vld_sr_d   = (vld_sr_q << 1) | LATENCY'(issue);
      inflight_d = inflight_q;
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      mem_d      = mem_q;

      if (issue) begin
         add_a_d  = bus.in_a;
         add_b_d  = bus.in_b;
         add_op_d = bus.in_op;
      end

      case ({issue, retire})
         2'b10:   inflight_d = inflight_q + CW'(1);
         2'b01:   inflight_d = inflight_q - CW'(1);
         default: inflight_d = inflight_q;
      endcase

      case ({retire, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (retire) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         add_a_q    <= '0;
         add_b_q    <= '0;
         add_op_q   <= 1'b0;
         vld_sr_q   <= '0;
         inflight_q <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         add_a_q    <= add_a_d;
         add_b_q    <= add_b_d;
         add_op_q   <= add_op_d;
         vld_sr_q   <= vld_sr_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Storage needs no reset: occupancy gates every read.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign bus.add_a     = add_a_q;
   assign bus.add_b     = add_b_q;
   assign bus.add_op    = add_op_q;
   assign bus.out_valid = (count_q != '0);
   assign bus.out_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign bus.busy      = (inflight_q != '0) || (count_q != '0);
endmodule

// File: tb/tb_fp_add_issuer.sv
// Directed bench for fp_add_issuer with a behavioural fixed-latency adder and an in-order result scoreboard.
module tb_fp_add_issuer;
   localparam int W     = 32;
   localparam int LAT   = 7;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fp_add_issuer_if #(.WIDTH(W)) bus ();

   fp_add_issuer #(.WIDTH(W), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   logic [W-1:0] exp_q[$];
   int acc_q[$];
   bit lat_chk = 1'b0;
   logic [W-1:0] mon_e;
   int mon_a;

   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in adder: integer add/sub on the raw bits, except the 1.0 + 2.0 case.
   function automatic logic [W-1:0] adder_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
      if (a == 32'h3F800000 && b == 32'h40000000 && !op) return 32'h40400000;
      return op ? a - b : a + b;
   endfunction

   logic [W-1:0] pipe [LAT-1];
   always @(posedge clk) begin
      pipe[0] <= adder_model(bus.add_a, bus.add_b, bus.add_op);
      for (int k = 1; k < LAT-1; k++) pipe[k] <= pipe[k-1];
   end
   assign bus.add_result = pipe[LAT-2];

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            chk("spurious_pop", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            mon_a = acc_q.pop_front();
            chk("result", bus.out_data, mon_e);
            if (lat_chk) chk("latency", W'(cyc - mon_a), W'(LAT));
         end
      end
   end

   function automatic logic [W-1:0] stim_a(input int i, input int s);
      return 32'h01000000 + W'(s) * 32'h00010000 + W'(i) * 32'h00000111;
   endfunction
   function automatic logic [W-1:0] stim_b(input int i);
      return 32'h00000200 + W'(i);
   endfunction
   function automatic logic stim_op(input int i);
      return i[0];
   endfunction

   task automatic set_data(input int i, input int s);
      bus.in_a  = stim_a(i, s);
      bus.in_b  = stim_b(i);
      bus.in_op = stim_op(i);
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic op, input logic [W-1:0] exp);
      bit done = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_a = a;
      bus.in_b = b;
      bus.in_op = op;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            exp_q.push_back(exp);
            acc_q.push_back(cyc + 1);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic offer(input int first, input int last, input int max_cyc, input int s, output int nxt);
      int idx = first;
      bus.in_valid = 1'b1;
      set_data(idx, s);
      for (int c = 0; c < max_cyc && idx < last; c++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            exp_q.push_back(stim_op(idx) ? stim_a(idx, s) - stim_b(idx) : stim_a(idx, s) + stim_b(idx));
            acc_q.push_back(cyc + 1);
            idx++;
         end
         @(posedge clk);
         #1;
         if (idx < last) set_data(idx, s);
      end
      bus.in_valid = 1'b0;
      nxt = idx;
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int c = 0; c < 300 && !done; c++) begin
         @(negedge clk);
         if (!bus.busy && exp_q.size() == 0) done = 1'b1;
      end
      chk("drain_busy", W'(bus.busy), 32'd0);
      chk("drain_pending", W'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nx;
      int last_acc;
      bit seen;
      bus.in_valid = 1'b0;
      bus.in_a = '0;
      bus.in_b = '0;
      bus.in_op = 1'b0;
      bus.out_ready = 1'b0;
      rst_n = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", W'(bus.in_ready), 32'd0);
      chk("rst_out_valid", W'(bus.out_valid), 32'd0);
      chk("rst_busy", W'(bus.busy), 32'd0);
      chk("rst_add_a", bus.add_a, 32'd0);
      chk("rst_add_op", W'(bus.add_op), 32'd0);
      chk("rst_out_data", bus.out_data, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("release_in_ready", W'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Single add, result LAT cycles after accept
      bus.out_ready = 1'b1;
      lat_chk = 1'b1;
      send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000);
      bus.in_valid = 1'b0;
      chk("add_a_loaded", bus.add_a, 32'h3F800000);
      chk("add_b_loaded", bus.add_b, 32'h40000000);
      chk("add_op_loaded", W'(bus.add_op), 32'd0);
      chk("busy_inflight", W'(bus.busy), 32'd1);
      wait_idle();

      // Negative zero canonicalisation, pass-through, subtract
      send(32'h80000000, 32'h00000000, 1'b0, 32'h00000000);
      send(32'h3F800000, 32'h00000000, 1'b0, 32'h3F800000);
      send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000);
      send(32'h40400000, 32'h3F800000, 1'b1, 32'h00C00000);
      bus.in_valid = 1'b0;
      chk("add_op_sub", W'(bus.add_op), 32'd1);
      wait_idle();

      // Streaming with out_ready held high
      offer(0, 8, 8, 1, nx);
      chk("stream_first8_b2b", W'(nx), 32'd8);
      offer(8, 20, 200, 1, nx);
      chk("stream_all20", W'(nx), 32'd20);
      wait_idle();
      lat_chk = 1'b0;

      // Back-pressure: exactly DEPTH accepted while out_ready is low
      bus.out_ready = 1'b0;
      offer(0, 10, 15, 2, nx);
      chk("bp_accepted", W'(nx), 32'd8);
      @(negedge clk);
      chk("bp_in_ready", W'(bus.in_ready), 32'd0);
      chk("bp_out_valid", W'(bus.out_valid), 32'd1);
      chk("bp_busy", W'(bus.busy), 32'd1);
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      offer(8, 10, 200, 2, nx);
      chk("bp_remaining", W'(nx), 32'd10);
      wait_idle();

      // Retire and pop in the same cycle with 7 entries buffered
      bus.out_ready = 1'b0;
      offer(0, 8, 8, 3, nx);
      chk("sim_accepted", W'(nx), 32'd8);
      last_acc = acc_q[acc_q.size()-1];
      while (cyc < last_acc + LAT - 1) begin
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("sim_in_ready_before", W'(bus.in_ready), 32'd0);
      chk("sim_out_valid", W'(bus.out_valid), 32'd1);
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      @(negedge clk);
      chk("sim_in_ready_after", W'(bus.in_ready), 32'd1);
      chk("sim_busy", W'(bus.busy), 32'd1);
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      wait_idle();

      // Reset with three ops in flight
      offer(0, 3, 10, 4, nx);
      chk("mid_accepted", W'(nx), 32'd3);
      @(posedge clk);
      #1 rst_n = 1'b0;
      exp_q.delete();
      acc_q.delete();
      @(negedge clk);
      chk("mid_rst_in_ready", W'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("mid_out_valid", W'(bus.out_valid), 32'd0);
      chk("mid_busy", W'(bus.busy), 32'd0);
      chk("mid_in_ready", W'(bus.in_ready), 32'd1);
      chk("mid_add_a", bus.add_a, 32'd0);
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      chk("mid_no_stale", W'(seen), 32'd0);
      @(posedge clk);
      #1 lat_chk = 1'b1;
      send(32'h00200000, 32'h00000300, 1'b0, 32'h00200300);
      bus.in_valid = 1'b0;
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
